// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared state encoding and cycle-count constants for the ARC4 engine
package arc4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
    ST_LEN,
    ST_DROPK,
    ST_PRGA,
    ST_DONE
  } arc4_state_t;

  localparam int S_SIZE           = 256;
  localparam int INIT_CYCLES      = S_SIZE;
  localparam int KSA_STEP_CYCLES  = 6;
  localparam int KSA_CYCLES       = KSA_STEP_CYCLES * S_SIZE;
  localparam int LEN_CYCLES       = 3;
  localparam int DROP_STEP_CYCLES = 8;
  localparam int PRGA_STEP_CYCLES = 9;
  localparam int DONE_CYCLES      = 1;
  localparam int BASE_CYCLES      = INIT_CYCLES + KSA_CYCLES + LEN_CYCLES + DONE_CYCLES;

  // Width of a counter that walks 0..n-1; a single-byte key still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arc4_key_mux.sv
// rtl/arc4_key_mux.sv - selects key byte idx from the latched key, byte 0 in the MSBs
module arc4_key_mux
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int IDX_W     = idx_width(KEY_BYTES)
) (
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [IDX_W-1:0]       idx,
  output logic [7:0]             key_byte
);

  // Plain compare-and-select so the index never needs a divider or shifter.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (idx == IDX_W'(b)) key_byte = key[8*(KEY_BYTES-1-b) +: 8];
    end
  end

endmodule

// File: rtl/arc4_engine.sv
// rtl/arc4_engine.sv - single-sequencer ARC4 decryptor with external S memory
module arc4_engine
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int DROP      = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic                   abort,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren
);

  localparam int          KI_W      = idx_width(KEY_BYTES);
  localparam logic [3:0]  KSA_LAST  = 4'(KSA_STEP_CYCLES - 1);
  localparam logic [3:0]  LEN_LAST  = 4'(LEN_CYCLES - 1);
  localparam logic [3:0]  DROP_LAST = 4'(DROP_STEP_CYCLES - 1);
  localparam logic [3:0]  PRGA_LAST = 4'(PRGA_STEP_CYCLES - 1);
  localparam logic [10:0] DCNT_LAST = 11'((DROP > 0) ? DROP - 1 : 0);
  localparam logic [7:0]  I_LAST    = 8'(S_SIZE - 1);

  arc4_state_t state, state_nx;

  logic [3:0]             ph;
  logic [7:0]             i, j, si, sj, ks, k, len;
  logic [KI_W-1:0]        ki;
  logic [10:0]            dcnt;
  logic [8*KEY_BYTES-1:0] key_reg;
  logic [7:0]             key_byte;
  logic [7:0]             i_inc, j_ksa, j_prga, t_idx;
  logic [3:0]             step_last;
  logic                   start;

  arc4_key_mux #(.KEY_BYTES(KEY_BYTES), .IDX_W(KI_W)) u_key_mux (
    .key      (key_reg),
    .idx      (ki),
    .key_byte (key_byte)
  );

  assign rdy       = (state == ST_IDLE);
  assign start     = en && !abort;
  assign i_inc     = i + 8'd1;
  assign j_ksa     = j + si + key_byte;
  assign j_prga    = j + si;
  assign t_idx     = si + sj;
  assign step_last = (state == ST_PRGA) ? PRGA_LAST : DROP_LAST;

  // State register; abort and reset both collapse to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state and the memory/port strobes for the current phase.
  always_comb begin
    state_nx  = state;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_INIT;
      ST_INIT: begin
        s_addr   = i;
        s_wrdata = i;
        s_wren   = 1'b1;
        if (i == I_LAST) state_nx = ST_KSA;
      end
      ST_KSA: begin
        case (ph)
          4'd0: s_addr = i;
          4'd2: s_addr = j_ksa;
          4'd4: begin s_addr = i; s_wrdata = sj; s_wren = 1'b1; end
          4'd5: begin
            s_addr   = j;
            s_wrdata = si;
            s_wren   = 1'b1;
            if (i == I_LAST) state_nx = ST_LEN;
          end
          default: ;
        endcase
      end
      ST_LEN: begin
        if (ph == LEN_LAST) begin
          pt_wren   = 1'b1;
          pt_wrdata = len;
          if (DROP > 0)          state_nx = ST_DROPK;
          else if (len == 8'd0)  state_nx = ST_DONE;
          else                   state_nx = ST_PRGA;
        end
      end
      ST_DROPK, ST_PRGA: begin
        if (state == ST_PRGA) ct_addr = k;
        case (ph)
          4'd0: s_addr = i_inc;
          4'd2: s_addr = j_prga;
          4'd4: begin s_addr = i; s_wrdata = sj; s_wren = 1'b1; end
          4'd5: begin s_addr = j; s_wrdata = si; s_wren = 1'b1; end
          4'd6: s_addr = t_idx;
          default: ;
        endcase
        if (state == ST_DROPK && ph == DROP_LAST && dcnt == DCNT_LAST)
          state_nx = (len == 8'd0) ? ST_DONE : ST_PRGA;
        if (state == ST_PRGA && ph == PRGA_LAST) begin
          pt_addr   = k;
          pt_wrdata = ct_rddata ^ ks;
          pt_wren   = 1'b1;
          if (k == len) state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  // Datapath: phase counter, i/j/key index, captured S bytes, byte counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph      <= '0;
      i       <= '0;
      j       <= '0;
      si      <= '0;
      sj      <= '0;
      ks      <= '0;
      k       <= '0;
      len     <= '0;
      ki      <= '0;
      dcnt    <= '0;
      key_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ph <= '0;
          i  <= '0;
          j  <= '0;
          ki <= '0;
          if (start) key_reg <= key;
        end
        ST_INIT: i <= i_inc;
        ST_KSA: begin
          ph <= (ph == KSA_LAST) ? 4'd0 : ph + 4'd1;
          case (ph)
            4'd1: si <= s_rddata;
            4'd2: j  <= j_ksa;
            4'd3: sj <= s_rddata;
            4'd5: begin
              i  <= i_inc;
              ki <= (ki == KI_W'(KEY_BYTES - 1)) ? '0 : ki + KI_W'(1);
            end
            default: ;
          endcase
        end
        ST_LEN: begin
          ph <= (ph == LEN_LAST) ? 4'd0 : ph + 4'd1;
          if (ph == 4'd1) len <= ct_rddata;
          if (ph == LEN_LAST) begin
            i    <= '0;
            j    <= '0;
            k    <= 8'd1;
            dcnt <= '0;
          end
        end
        ST_DROPK, ST_PRGA: begin
          ph <= (ph == step_last) ? 4'd0 : ph + 4'd1;
          case (ph)
            4'd0: i  <= i_inc;
            4'd1: si <= s_rddata;
            4'd2: j  <= j_prga;
            4'd3: sj <= s_rddata;
            4'd7: ks <= s_rddata;
            default: ;
          endcase
          if (state == ST_DROPK && ph == DROP_LAST) dcnt <= dcnt + 11'd1;
          if (state == ST_PRGA && ph == PRGA_LAST)  k <= k + 8'd1;
        end
        default: ph <= '0;
      endcase
    end
  end

endmodule
